// File: rtl/musicbox_pkg.sv
// Shared types and constants for the music-box note sequencer.
package musicbox_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      CHECK = 2'd2,
      HOLD  = 2'd3
   } seq_state_t;

   localparam int NOTE_REST        = 0;
   localparam int END_CODE_DEFAULT = 255;

   // Song-select width; a single-song build still carries a one-bit select.
   function automatic int sel_w(input int num_songs);
      if (num_songs <= 1) begin
         return 1;
      end else begin
         return $clog2(num_songs);
      end
   endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, ROM and playback-status bundle for note_sequencer.
// Optional MUSICBOX_TRANSPOSE_EN adds the transpose input.
interface note_sequencer_if #(
   parameter int NOTE_W = 8,
   parameter int ADDR_W = 10,
   parameter int SEL_W  = 1
);
   logic              start;
   logic              stop;
   logic              pause;
   logic [SEL_W-1:0]  song_sel;
   logic              loop_en;
   logic              tick;
   logic [ADDR_W-1:0] rom_addr;
   logic [NOTE_W-1:0] rom_data;
   logic [NOTE_W-1:0] note;
   logic              playing;
   logic              song_done;
   logic [ADDR_W-1:0] beat_idx;
`ifdef MUSICBOX_TRANSPOSE_EN
   logic [5:0]        transpose;
`endif

   modport master (
`ifdef MUSICBOX_TRANSPOSE_EN
      output transpose,
`endif
      output start, stop, pause, song_sel, loop_en, tick, rom_data,
      input  rom_addr, note, playing, song_done, beat_idx
   );

   modport slave (
`ifdef MUSICBOX_TRANSPOSE_EN
      input  transpose,
`endif
      input  start, stop, pause, song_sel, loop_en, tick, rom_data,
      output rom_addr, note, playing, song_done, beat_idx
   );

endinterface

// File: rtl/note_sequencer.sv
// Multi-song note sequencer: steps an external 1-cycle-latency note ROM per tempo tick.
// Define MUSICBOX_TRANSPOSE_EN to add saturating transpose of fetched notes.
module note_sequencer
   import musicbox_pkg::*;
#(
   parameter int NOTE_W     = 8,
   parameter int NUM_SONGS  = 2,
   parameter int SONG_DEPTH = 512,
   parameter int ADDR_W     = 10,
   parameter int END_CODE   = END_CODE_DEFAULT
) (
   input logic             clk,
   input logic             rst_n,
   note_sequencer_if.slave bus
);

   localparam int                SEL_W       = sel_w(NUM_SONGS);
   localparam logic [SEL_W:0]    NUM_SONGS_C = (SEL_W+1)'(NUM_SONGS);
   localparam logic [NOTE_W-1:0] END_C       = NOTE_W'(END_CODE);
   localparam logic [NOTE_W-1:0] REST_C      = NOTE_W'(NOTE_REST);
   localparam logic [ADDR_W-1:0] LAST_C      = ADDR_W'(SONG_DEPTH - 1);
   localparam logic [ADDR_W-1:0] DEPTH_C     = ADDR_W'(SONG_DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_ADDR_C = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ONE_ADDR_C  = ADDR_W'(1);

   if ((2 ** ADDR_W) < (NUM_SONGS * SONG_DEPTH)) begin : g_addr_check
      $error("note_sequencer: ADDR_W too small for NUM_SONGS*SONG_DEPTH");
   end

   seq_state_t        state_r, state_nxt_s;
   logic [ADDR_W-1:0] base_r, base_nxt_s, rom_addr_r, rom_addr_nxt_s;
   logic [ADDR_W-1:0] beat_idx_r, beat_idx_nxt_s, start_base_s;
   logic [NOTE_W-1:0] note_r, note_nxt_s, fetched_note_s;
   logic              song_done_r, song_done_nxt_s, playing_r;
   logic              tick_pending_r, tick_pending_nxt_s;
   logic              start_ok_s, end_code_s, advance_s, last_entry_s, song_end_s;

   assign start_ok_s   = bus.start && ({1'b0, bus.song_sel} < NUM_SONGS_C);
   assign start_base_s = ADDR_W'(bus.song_sel) * DEPTH_C;
   assign end_code_s   = (bus.rom_data == END_C);
   assign advance_s    = (bus.tick || tick_pending_r) && !bus.pause;
   assign last_entry_s = (beat_idx_r == LAST_C);
   // Both END_CODE and running off the last reserved entry finish the song the same way.
   assign song_end_s   = ((state_r == CHECK) && end_code_s) ||
                         ((state_r == HOLD) && advance_s && last_entry_s);

`ifdef MUSICBOX_TRANSPOSE_EN
   localparam logic signed [NOTE_W+1:0] LO_C = (NOTE_W+2)'(1);
   localparam logic signed [NOTE_W+1:0] HI_C = (NOTE_W+2)'(END_CODE - 1);
   logic [5:0] transpose_r;

   function automatic logic [NOTE_W-1:0] transpose_note(input logic [NOTE_W-1:0] raw,
                                                        input logic [5:0]        offs);
      logic signed [NOTE_W+1:0] sum;
      sum = $signed({2'b00, raw}) + $signed({{(NOTE_W-4){offs[5]}}, offs});
      if (raw == REST_C) begin
         return REST_C;
      end else if (sum < LO_C) begin
         return LO_C[NOTE_W-1:0];
      end else if (sum > HI_C) begin
         return HI_C[NOTE_W-1:0];
      end else begin
         return sum[NOTE_W-1:0];
      end
   endfunction

   // Transpose offset captured together with an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         transpose_r <= 6'd0;
      end else if (!bus.stop && start_ok_s) begin
         transpose_r <= bus.transpose;
      end else begin
         transpose_r <= transpose_r;
      end
   end

   assign fetched_note_s = transpose_note(bus.rom_data, transpose_r);
`else
   assign fetched_note_s = bus.rom_data;
`endif

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         base_r         <= ZERO_ADDR_C;
         rom_addr_r     <= ZERO_ADDR_C;
         beat_idx_r     <= ZERO_ADDR_C;
         note_r         <= REST_C;
         song_done_r    <= 1'b0;
         playing_r      <= 1'b0;
         tick_pending_r <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         base_r         <= base_nxt_s;
         rom_addr_r     <= rom_addr_nxt_s;
         beat_idx_r     <= beat_idx_nxt_s;
         note_r         <= note_nxt_s;
         song_done_r    <= song_done_nxt_s;
         playing_r      <= (state_nxt_s != IDLE);
         tick_pending_r <= tick_pending_nxt_s;
      end
   end

   // Next-state selection; stop outranks start, start outranks normal stepping.
   always_comb begin
      state_nxt_s = state_r;
      if (bus.stop) begin
         state_nxt_s = IDLE;
      end else if (start_ok_s) begin
         state_nxt_s = FETCH;
      end else if (song_end_s) begin
         state_nxt_s = bus.loop_en ? FETCH : IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = IDLE;
            FETCH:   state_nxt_s = CHECK;
            CHECK:   state_nxt_s = HOLD;
            HOLD:    state_nxt_s = advance_s ? FETCH : HOLD;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Next values of address, beat, note, pending tick and done pulse.
   always_comb begin
      base_nxt_s         = base_r;
      rom_addr_nxt_s     = rom_addr_r;
      beat_idx_nxt_s     = beat_idx_r;
      note_nxt_s         = note_r;
      tick_pending_nxt_s = tick_pending_r;
      song_done_nxt_s    = 1'b0;
      if (bus.stop) begin
         note_nxt_s         = REST_C;
         tick_pending_nxt_s = 1'b0;
      end else if (start_ok_s) begin
         base_nxt_s         = start_base_s;
         rom_addr_nxt_s     = start_base_s;
         beat_idx_nxt_s     = ZERO_ADDR_C;
         tick_pending_nxt_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: note_nxt_s = REST_C;
            FETCH, CHECK: begin
               if (bus.tick) begin
                  tick_pending_nxt_s = 1'b1;
               end else begin
                  tick_pending_nxt_s = tick_pending_r;
               end
               if ((state_r == CHECK) && !end_code_s) begin
                  note_nxt_s = fetched_note_s;
               end else begin
                  note_nxt_s = note_r;
               end
            end
            HOLD: begin
               if (advance_s && !last_entry_s) begin
                  tick_pending_nxt_s = 1'b0;
                  rom_addr_nxt_s     = rom_addr_r + ONE_ADDR_C;
                  beat_idx_nxt_s     = beat_idx_r + ONE_ADDR_C;
               end else if (advance_s) begin
                  tick_pending_nxt_s = 1'b0;
               end else begin
                  tick_pending_nxt_s = tick_pending_r;
               end
            end
            default: note_nxt_s = REST_C;
         endcase
         if (song_end_s && bus.loop_en) begin
            rom_addr_nxt_s = base_r;
            beat_idx_nxt_s = ZERO_ADDR_C;
         end else if (song_end_s) begin
            note_nxt_s         = REST_C;
            song_done_nxt_s    = 1'b1;
            tick_pending_nxt_s = 1'b0;
         end else begin
            song_done_nxt_s = 1'b0;
         end
      end
   end

   assign bus.rom_addr  = rom_addr_r;
   assign bus.beat_idx  = beat_idx_r;
   assign bus.note      = note_r;
   assign bus.song_done = song_done_r;
   assign bus.playing   = playing_r;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Parametrised multi-song playback sequencer for the music box. It steps a synchronous note ROM (1-cycle read latency) one entry per tempo tick and holds the current note index for the tone generator. It adds song select, an end-of-song code, looping, pause and stop. The song ROMs sit outside this block; it sits between the ROMs and the tone generator.

Parameters:
NOTE_W, 8, note index width; 0 = rest
NUM_SONGS, 2, songs packed back to back in one ROM address space
SONG_DEPTH, 512, entries reserved per song; song base = song_sel*SONG_DEPTH
ADDR_W, 10, ROM address width; elaboration error if 2**ADDR_W < NUM_SONGS*SONG_DEPTH
END_CODE, 255, ROM value marking end of song

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin song song_sel from entry 0
stop  in  1  level/pulse: abort playback
pause  in  1  level: freeze on current note
song_sel  in  SEL_W=max(1,$clog2(NUM_SONGS))  song index, sampled with start
loop_en  in  1  level: restart song at END instead of finishing
tick  in  1  one-cycle beat strobe
rom_addr  out  ADDR_W  ROM read address
rom_data  in  NOTE_W  ROM data, valid 1 cycle after rom_addr
note  out  NOTE_W  current note index, registered
playing  out  1  high in any state other than IDLE
song_done  out  1  one-cycle pulse on non-looping end
beat_idx  out  ADDR_W  offset of current entry within song

Behaviour:
- Reset values: all outputs 0, state IDLE, tick_pending 0.
- States: IDLE, FETCH, CHECK, HOLD.
- IDLE: note=0. If start=1 and song_sel<NUM_SONGS: latch base, rom_addr<=base, beat_idx<=0, go to FETCH. If song_sel>=NUM_SONGS, start is ignored.
- FETCH: wait one cycle for ROM latency, then go to CHECK.
- CHECK:
  - rom_data==END_CODE: if loop_en, rom_addr<=base, beat_idx<=0, go to FETCH (note keeps its old value). Otherwise note<=0, song_done<=1 for one cycle, go to IDLE.
  - Any other value: note<=rom_data, go to HOLD.
- HOLD: advance when (tick or tick_pending) and !pause.
  - If beat_idx==SONG_DEPTH-1: end-of-song handling identical to END_CODE.
  - Otherwise beat_idx++, rom_addr++, go to FETCH.
- Latency: start sampled at edge N gives note updated at edge N+2.
- tick arriving in FETCH/CHECK sets tick_pending; tick_pending is cleared when consumed in HOLD. At most one tick is queued; extra ticks are dropped.
- pause: ticks are ignored (not queued) while pause=1 in HOLD. note and rom_addr hold. pause has no effect in other states.
- stop: highest priority, valid in any state. Next edge: IDLE, note=0, tick_pending=0, song_done stays 0.
- start while playing (stop=0): restart immediately with the new song_sel, same as start from IDLE.
- stop and start in the same cycle: stop wins.
- A 0 (rest) in the ROM is a normal note and is held like any other value.
- Reset asserted mid-song: immediate return to reset values.

Optional Feature:
MUSICBOX_TRANSPOSE_EN
- Enabled: adds input transpose [5:0], signed semitone offset, sampled at start. On CHECK, note = rom_data + transpose, saturated to [1, END_CODE-1]. Rests (0) stay 0. END_CODE detection uses the raw rom_data.
- Disabled: port absent; note = rom_data unchanged.

Decomposition:
- Package musicbox_pkg holds:
  - state enum (IDLE/FETCH/CHECK/HOLD)
  - NOTE_REST=0 and default END_CODE constants
  - SEL_W computation function
- No sub-module; the ROM stays external. The bench instantiates a behavioural ROM model with 1-cycle read latency.

Test Plan:
- Reset, then song 0 with ROM {34,34,39,END}, tick every 8 cycles -> note sequence 34,34,39, then 0; song_done pulses once; playing falls; rom_addr visits 0..3.
- start with song_sel=1 -> first rom_addr=512; note equals ROM[512] two cycles after start.
- loop_en=1, ROM {41,END} -> note stays 41 across the wrap; beat_idx returns to 0; no song_done in 3 passes.
- pause high during HOLD for 5 ticks -> note frozen, rom_addr unchanged. After pause falls, the next tick advances exactly one entry.
- stop asserted in FETCH, and stop+start asserted together -> note=0, IDLE on the next edge, no song_done.
- song_sel=2 with NUM_SONGS=2 -> start ignored, playing stays 0. Song with no END_CODE -> ends after entry 511 with song_done.
